button_frontend: RTL and testbench

Synchronizes, debounces and edge-detects the raw Basys3 push-buttons, and adds typematic auto-repeat on held buttons. Sits between the board pins (btnC/U/D/L/R) and the mode/command logic in the top level. It replaces per-button conditioner instances with one block whose pulses let a held direction button step the cursor repeatedly.

---
 rtl/button_frontend.sv | 136 +++++++++++++
 tb/tb_button_frontend.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_frontend.sv
// Push-button conditioner: 2-flop synchronizer, per-channel debounce, press strobe and
// optional typematic auto-repeat (enabled by defining BTN_AUTOREPEAT_EN).
module button_frontend #(
  parameter int              NBTN                = 5,
  parameter int              DEBOUNCE_CYCLES     = 1_000_000,
  parameter int              REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int              REPEAT_RATE_CYCLES  = 10_000_000,
  parameter logic [NBTN-1:0] REPEAT_MASK         = 5'b11110
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_pulse
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] level_q, level_d;
  logic [NBTN-1:0] pulse_q, pulse_d;
  logic [NBTN-1:0] rise;
  logic [DB_W-1:0] db_cnt_q [NBTN];
  logic [DB_W-1:0] db_cnt_d [NBTN];

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      db_cnt_d[i] = '0;
      level_d[i]  = level_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) level_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Decisions use the next level so the strobe lands in the first cycle the level is high.
  assign rise = level_d & ~level_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int               TMR_W      = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(REPEAT_RATE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HELD   = 2'd1;
  localparam logic [1:0] ST_DELAY  = 2'd2;
  localparam logic [1:0] ST_REPEAT = 2'd3;

  logic [1:0]       state_q [NBTN];
  logic [1:0]       state_d [NBTN];
  logic [TMR_W-1:0] tmr_q   [NBTN];
  logic [TMR_W-1:0] tmr_d   [NBTN];

  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      state_d[i] = state_q[i];
      tmr_d[i]   = tmr_q[i];
      pulse_d[i] = 1'b0;
      if (!level_d[i]) begin
        state_d[i] = ST_IDLE;
        tmr_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (rise[i]) begin
              pulse_d[i] = 1'b1;
              if (REPEAT_MASK[i]) begin
                state_d[i] = ST_DELAY;
                tmr_d[i]   = DELAY_LOAD;
              end else begin
                state_d[i] = ST_HELD;
              end
            end
          end
          ST_HELD: state_d[i] = ST_HELD;
          ST_DELAY, ST_REPEAT: begin
            if (tmr_q[i] == '0) begin
              pulse_d[i] = 1'b1;
              tmr_d[i]   = RATE_LOAD;
              state_d[i] = ST_REPEAT;
            end else begin
              tmr_d[i] = tmr_q[i] - TMR_W'(1);
            end
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= ST_IDLE;
        tmr_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES};
  assign pulse_d = rise;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the counter arrays are plain flops, not RAM, so they are cleared element by element in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NBTN; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_button_frontend.sv
// Self-checking bench for button_frontend: directed scenarios plus random button activity,
// compared every cycle against a window/arithmetic reference model.
module tb_button_frontend;

  localparam int NBTN = 5;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NBTN-1:0] btn_raw = '0;
  logic [NBTN-1:0] btn_level, btn_pulse;
  logic [NBTN-1:0] rep_mask = 5'b11110;

  always #5 clk = ~clk;

  button_frontend #(
    .NBTN(NBTN), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES(RR), .REPEAT_MASK(5'b11110)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  // Reference model: raw samples per edge, level accepted after DB equal synchronized samples,
  // pulses at press time T0 and at T0+RD+k*RR for repeat-enabled channels.
  logic [DB+1:0]   hist [NBTN];
  logic [NBTN-1:0] m_level = '0;
  logic [NBTN-1:0] m_pulse = '0;
  int              t0 [NBTN];

  task automatic model_edge();
    int  age;
    logic prev;
    for (int i = 0; i < NBTN; i++) begin
      if (reset) begin
        hist[i]    = '0;
        m_level[i] = 1'b0;
        m_pulse[i] = 1'b0;
        t0[i]      = 0;
      end else begin
        hist[i] = {hist[i][DB:0], btn_raw[i]};
        prev    = m_level[i];
        if (&hist[i][DB+1:2])       m_level[i] = 1'b1;
        else if (~|hist[i][DB+1:2]) m_level[i] = 1'b0;
        m_pulse[i] = 1'b0;
        if (m_level[i] && !prev) begin
          t0[i]      = cyc;
          m_pulse[i] = 1'b1;
        end else if (m_level[i] && AR && rep_mask[i]) begin
          age = cyc - t0[i];
          if (age >= RD && (age - RD) % RR == 0) m_pulse[i] = 1'b1;
        end
      end
    end
  endtask

  // Observed-DUT statistics used by the directed scenarios.
  int pulse_cnt [NBTN];
  int high_cnt  [NBTN];
  int first_pulse [NBTN];
  int last_pulse  [NBTN];
  int rise_cyc [NBTN];
  int fall_cyc [NBTN];
  logic [NBTN-1:0] prev_lvl = '0;

  task automatic clear_stats();
    for (int i = 0; i < NBTN; i++) begin
      pulse_cnt[i] = 0; high_cnt[i] = 0;
      first_pulse[i] = -1; last_pulse[i] = -1;
      rise_cyc[i] = -1; fall_cyc[i] = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("level", 32'(btn_level), 32'(m_level));
    check("pulse", 32'(btn_pulse), 32'(m_pulse));
    for (int i = 0; i < NBTN; i++) begin
      if (btn_pulse[i]) begin
        pulse_cnt[i]++;
        if (first_pulse[i] < 0) first_pulse[i] = cyc;
        last_pulse[i] = cyc;
      end
      if (btn_level[i]) high_cnt[i]++;
      if (btn_level[i] && !prev_lvl[i]) rise_cyc[i] = cyc;
      if (!btn_level[i] && prev_lvl[i]) fall_cyc[i] = cyc;
    end
    prev_lvl = btn_level;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int e0, rel, rc;
    logic [NBTN-1:0] target;
    clear_stats();
    for (int i = 0; i < NBTN; i++) begin hist[i] = '0; t0[i] = 0; end

    // Reset state
    run(2);
    check("reset_level", 32'(btn_level), 0);
    check("reset_pulse", 32'(btn_pulse), 0);
    reset = 1'b0;
    run(3);

    // Bounce rejection on btnU
    clear_stats();
    for (int k = 0; k < 30; k++) begin
      btn_raw[1] = ((k >> 1) & 1) == 0;
      step();
    end
    btn_raw[1] = 1'b0;
    run(10);
    check("bounce_level_cycles", high_cnt[1], 0);
    check("bounce_pulses", pulse_cnt[1], 0);

    // Clean press on btnL
    clear_stats();
    btn_raw[3] = 1'b1;
    step(); e0 = cyc;
    run(9);
    btn_raw[3] = 1'b0;
    step(); rel = cyc;
    run(12);
    check("press_rise_latency", rise_cyc[3] - e0, 5);
    check("press_pulse_cycle", first_pulse[3] - e0, 5);
    check("press_pulse_count", pulse_cnt[3], 1);
    check("release_fall_latency", fall_cyc[3] - rel, 5);

    // Auto-repeat on btnR, level high for 60 cycles
    clear_stats();
    btn_raw[4] = 1'b1;
    step(); e0 = cyc;
    run(59);
    btn_raw[4] = 1'b0;
    run(10);
    check("repeat_level_cycles", high_cnt[4], 60);
    check("repeat_pulse_count", pulse_cnt[4], AR ? 9 : 1);
    check("repeat_last_pulse", last_pulse[4] - (e0 + 5), AR ? 55 : 0);

    // Masked center with simultaneous btnD
    clear_stats();
    btn_raw[0] = 1'b1; btn_raw[2] = 1'b1;
    step(); e0 = cyc;
    run(99);
    btn_raw[0] = 1'b0; btn_raw[2] = 1'b0;
    run(10);
    check("center_pulse_count", pulse_cnt[0], 1);
    check("center_level_cycles", high_cnt[0], 100);
    check("center_first_pulse", first_pulse[0] - e0, 5);
    check("down_first_pulse", first_pulse[2] - e0, 5);
    check("down_pulse_count", pulse_cnt[2], AR ? 17 : 1);

    // Release landing on timer expiry (btnU, level high T0..T0+24)
    clear_stats();
    btn_raw[1] = 1'b1;
    step(); e0 = cyc;
    run(24);
    btn_raw[1] = 1'b0;
    run(10);
    check("expiry_level_cycles", high_cnt[1], 25);
    check("expiry_pulse_count", pulse_cnt[1], AR ? 2 : 1);
    clear_stats();
    btn_raw[1] = 1'b1;
    step(); e0 = cyc;
    run(9);
    btn_raw[1] = 1'b0;
    run(10);
    check("expiry_repress_cycle", first_pulse[1] - e0, 5);
    check("expiry_repress_count", pulse_cnt[1], 1);

    // Reset mid-repeat with btnR still held
    btn_raw[4] = 1'b1;
    step(); e0 = cyc;
    run(29);
    clear_stats();
    reset = 1'b1;
    step(); rc = cyc;
    check("midrst_level", 32'(btn_level), 0);
    check("midrst_pulse", 32'(btn_pulse), 0);
    reset = 1'b0;
    run(15);
    check("midrst_repress_cycle", first_pulse[4] - rc, 6);
    btn_raw[4] = 1'b0;
    run(10);

    // Random activity with occasional glitches and resets
    target = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NBTN; i++) begin
        if ($urandom_range(0, 99) < 4) target[i] = ~target[i];
        btn_raw[i] = ($urandom_range(0, 99) < 8) ? ~target[i] : target[i];
      end
      reset = ($urandom_range(0, 699) == 0);
      step();
    end
    reset = 1'b0;
    btn_raw = '0;
    run(12);
    check("final_level", 32'(btn_level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
